// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the word-serial wide adder: word width, FSM states and
// the index-width helper used to size the word counter.
package wide_add_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wadd_state_e;

    // A single-word operand still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_cla.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups whose group
// generate/propagate terms produce the carry into the next group.
module cla_adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    // Per-group lookahead carries, then sum bits from propagate xor carry.
    always_comb begin : cla_calc
        logic [31:0] g_v;
        logic [31:0] p_v;
        logic [32:0] c_v;
        logic        gg_v;
        logic        pg_v;
        int          b;
        g_v    = a_i & b_i;
        p_v    = a_i ^ b_i;
        c_v    = 33'd0;
        gg_v   = 1'b0;
        pg_v   = 1'b0;
        c_v[0] = cin_i;
        for (int k = 0; k < 8; k++) begin
            b = 4 * k;
            c_v[b+1] = g_v[b] | (p_v[b] & c_v[b]);
            c_v[b+2] = g_v[b+1] | (p_v[b+1] & g_v[b]) | (p_v[b+1] & p_v[b] & c_v[b]);
            c_v[b+3] = g_v[b+2] | (p_v[b+2] & g_v[b+1]) | (p_v[b+2] & p_v[b+1] & g_v[b])
                     | (p_v[b+2] & p_v[b+1] & p_v[b] & c_v[b]);
            gg_v = g_v[b+3] | (p_v[b+3] & g_v[b+2]) | (p_v[b+3] & p_v[b+2] & g_v[b+1])
                 | (p_v[b+3] & p_v[b+2] & p_v[b+1] & g_v[b]);
            pg_v = p_v[b+3] & p_v[b+2] & p_v[b+1] & p_v[b];
            c_v[b+4] = gg_v | (pg_v & c_v[b]);
        end
        sum_o  = p_v ^ c_v[31:0];
        cout_o = c_v[32];
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial wide adder: latches WORDS*32-bit operands, adds one word per cycle
// (least significant first) through a single CLA, and holds the result until taken.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [WORDS*WORD_W-1:0]   a_i,
    input  logic [WORDS*WORD_W-1:0]   b_i,
    input  logic                      cin_i,
    input  logic                      abort_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [WORDS*WORD_W-1:0]   sum_o,
    output logic                      cout_o,
    output logic                      busy_o
);

    localparam int                OP_W     = WORDS * WORD_W;
    localparam int                IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    wadd_state_e        state_r;
    wadd_state_e        state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [OP_W-1:0]    a_op_r;
    logic [OP_W-1:0]    b_op_r;
    logic [OP_W-1:0]    sum_r;
    logic               cout_r;
    logic               rsp_valid_r;
    logic [WORD_W-1:0]  add_a_s;
    logic [WORD_W-1:0]  add_b_s;
    logic [WORD_W-1:0]  add_sum_s;
    logic               add_cout_s;
    logic               last_s;

    assign last_s      = (idx_r == LAST_IDX);
    assign req_ready_o = (state_r == ST_IDLE);
    assign busy_o      = (state_r != ST_IDLE);
    assign rsp_valid_o = rsp_valid_r;
    assign sum_o       = sum_r;
    assign cout_o      = cout_r;

    // Select the current word of each registered operand for the adder.
    always_comb begin
        add_a_s = a_op_r[int'(idx_r)*WORD_W +: WORD_W];
        add_b_s = b_op_r[int'(idx_r)*WORD_W +: WORD_W];
    end

    cla_adder_32bit u_cla (
        .a_i    (add_a_s),
        .b_i    (add_b_s),
        .cin_i  (carry_r),
        .sum_o  (add_sum_s),
        .cout_o (add_cout_s)
    );

    // Next-state decode; abort takes priority over the response handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (abort_i)     state_nxt_s = ST_IDLE;
                else if (last_s) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (abort_i)          state_nxt_s = ST_IDLE;
                else if (rsp_ready_i) state_nxt_s = ST_IDLE;
                else                  state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, operand capture, per-word accumulation and result hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= 1'b0;
            a_op_r      <= {OP_W{1'b0}};
            b_op_r      <= {OP_W{1'b0}};
            sum_r       <= {OP_W{1'b0}};
            cout_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        a_op_r  <= a_i;
                        b_op_r  <= b_i;
                        carry_r <= cin_i;
                        idx_r   <= {IDX_W{1'b0}};
                        sum_r   <= {OP_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        carry_r <= 1'b0;
                    end else begin
                        sum_r[int'(idx_r)*WORD_W +: WORD_W] <= add_sum_s;
                        carry_r <= add_cout_s;
                        // The index parks on the last word instead of wrapping.
                        if (last_s) begin
                            cout_r      <= add_cout_s;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (abort_i) begin
                        carry_r     <= 1'b0;
                        rsp_valid_r <= 1'b0;
                    end else if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: a cycle-level reference of the handshake/latency behaviour
// plus plain wide arithmetic, checked every cycle, and directed literal vectors.
module tb_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int OP_W  = WORDS * 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, cin, abort, rsp_valid, rsp_ready, cout, busy;
    logic [OP_W-1:0] a, b, sum;

    logic            rv1, rr1, cin1, abort1, rdy1, vld1, cout1, busy1;
    logic [31:0]     a1, b1, sum1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .abort_i(abort), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready), .sum_o(sum), .cout_o(cout), .busy_o(busy)
    );

    wide_add_sequencer #(.WORDS(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv1), .req_ready_o(rdy1),
        .a_i(a1), .b_i(b1), .cin_i(cin1), .abort_i(abort1), .rsp_valid_o(vld1),
        .rsp_ready_i(rr1), .sum_o(sum1), .cout_o(cout1), .busy_o(busy1)
    );

    function automatic logic [OP_W:0] model_add(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y,
                                                input logic c);
        return {1'b0, x} + {1'b0, y} + {{OP_W{1'b0}}, c};
    endfunction

    task automatic check(input string name, input logic [OP_W:0] act, input logic [OP_W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 0 idle, 1 computing (m_rem cycles left), 2 result held.
    int              m_phase = 0;
    int              m_rem   = 0;
    logic [OP_W:0]   m_res   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_rem   <= 0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    m_res   <= model_add(a, b, cin);
                    m_rem   <= WORDS;
                    m_phase <= 1;
                end
                1: if (abort) m_phase <= 0;
                   else if (m_rem == 1) m_phase <= 2;
                   else m_rem <= m_rem - 1;
                2: if (abort || rsp_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready", req_ready, m_phase == 0);
            check("cyc_busy", busy, m_phase != 0);
            check("cyc_valid", rsp_valid, m_phase == 2);
            if (m_phase == 2) begin
                check("cyc_sum", sum, m_res[OP_W-1:0]);
                check("cyc_cout", cout, m_res[OP_W]);
            end
        end
    end

    task automatic launch(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y, input logic c);
        int t;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("ready_wait", req_ready, 1'b1);
        a = x; b = y; cin = c; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = ~x; b = ~y; cin = ~c;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [OP_W-1:0] x, input logic [OP_W-1:0] y,
                          input logic c, input logic [OP_W-1:0] exp_sum, input logic exp_cout);
        int lat;
        check({name, "_model"}, model_add(x, y, c), {exp_cout, exp_sum});
        launch(x, y, c);
        wait_rsp(lat);
        check({name, "_latency"}, lat, WORDS);
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_cout"}, cout, exp_cout);
        release_rsp();
        check({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b1; req_valid = 1'b0; a = '0; b = '0; cin = 1'b0; abort = 1'b0; rsp_ready = 1'b0;
        rv1 = 1'b0; a1 = 32'd0; b1 = 32'd0; cin1 = 1'b0; abort1 = 1'b0; rr1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 1'b0);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("allones", {OP_W{1'b1}}, 128'd0, 1'b1, 128'd0, 1'b1);
        run_op("chain", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
               128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
        run_op("msb", {4{32'h8000_0000}}, {4{32'h8000_0000}}, 1'b0,
               128'h0000_0001_0000_0001_0000_0001_0000_0000, 1'b1);

        // Backpressure: result held for 5 cycles, new request refused.
        launch(128'd1, 128'd2, 1'b0);
        wait_rsp(lat);
        check("bp_latency", lat, WORDS);
        a = 128'd9; b = 128'd9; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_sum", sum, 128'd3);
            check("bp_cout", cout, 1'b0);
            check("bp_ready", req_ready, 1'b0);
            check("bp_valid", rsp_valid, 1'b1);
        end
        req_valid = 1'b0;
        release_rsp();

        // Abort while the third word is being added.
        launch({OP_W{1'b1}}, 128'd1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        repeat (6) begin @(posedge clk); #1; end
        check("abort_novalid", rsp_valid, 1'b0);
        run_op("after_abort", 128'd5, 128'd7, 1'b0, 128'd12, 1'b0);

        // Asynchronous reset in the middle of a run.
        launch({OP_W{1'b1}}, {OP_W{1'b1}}, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 1'b0);
        check("arst_valid", rsp_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", req_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op("post_rst", 128'd100, 128'd23, 1'b1, 128'd124, 1'b0);

        // Single-word instance.
        check("w1_ready", rdy1, 1'b1);
        a1 = 32'hFFFF_FFFF; b1 = 32'd1; cin1 = 1'b0; rv1 = 1'b1;
        @(posedge clk); #1;
        rv1 = 1'b0; a1 = 32'd0;
        lat = 0;
        while (!vld1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("w1_latency", lat, 1);
        check("w1_sum", sum1, 32'd0);
        check("w1_cout", cout1, 1'b1);
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        check("w1_release", vld1, 1'b0);
        check("w1_idle", busy1, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
